u_xmit_arb: RTL and testbench
=============================

U_XMIT_ARB -- requirements
Module: u_xmit_arb

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of grant_idH; equals ceil(log2(NUM_REQ)).
- TIMEOUT, 255, cycles allowed in each wait state (1..255); the counter is 8 bits.
REQ-002 Ports, one per line: name, direction, width, meaning.
- sys_clk, in, 1, single clock; all state changes on its rising edge.
- sys_rst_l, in, 1, asynchronous active-low reset.
- req_validH, in, NUM_REQ, requester i has a byte pending.
- req_dataH, in, 8*NUM_REQ, byte of requester i, carried in bits [8i+7:8i].
- req_readyH, out, NUM_REQ, one-cycle one-hot pulse; the byte of requester i is accepted.
- xmitH, out, 1, start-of-frame strobe to the UART transmitter.
- xmit_dataH, out, 8, byte to the transmitter.
- xmit_doneH, in, 1, transmitter idle/done; high while the transmitter is idle.
- grant_idH, out, ID_W, index of the last accepted requester.
- busyH, out, 1, a frame is in flight.
- err_timeoutH, out, 1, sticky timeout flag.
- err_clrH, in, 1, clears err_timeoutH.
REQ-003 Clock and reset are fixed: one clock, sys_clk; reset sys_rst_l, asynchronous, active-low.

Function
REQ-004 The FSM has exactly four states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
REQ-005 IDLE, when xmit_doneH=1 and any req_validH bit is set:
- the arbiter selects requester i by round-robin;
- it pulses req_readyH[i] for exactly one cycle;
- on the same edge it latches req_dataH[i] into the hold register and i into grant_idH;
- the next state is LAUNCH.
REQ-006 IDLE while xmit_doneH=0: no acceptance and no req_readyH, even if requests are valid.
REQ-007 Round-robin rule:
- the highest priority goes to the requester index one above the last grant, wrapping NUM_REQ-1 -> 0;
- after reset, index 0 has the highest priority;
- the priority pointer updates only on acceptance.
REQ-008 LAUNCH: xmitH=1 for exactly one cycle, then WAIT_BUSY; xmitH=0 in every other state.
REQ-009 xmit_dataH always equals the hold register.
- The hold register changes only on acceptance.
- It is stable from LAUNCH until the return to IDLE.
REQ-010 WAIT_BUSY: xmit_doneH=0 -> WAIT_DONE.
REQ-011 WAIT_DONE: xmit_doneH=1 -> IDLE. The next acceptance can happen no earlier than the cycle after the return to IDLE.
REQ-012 Timeout counter:
- cleared on entry to WAIT_BUSY and to WAIT_DONE;
- increments each cycle spent in those states;
- saturates at 255.
REQ-013 If the counter reaches TIMEOUT in WAIT_BUSY or WAIT_DONE:
- err_timeoutH is set;
- the next state is IDLE;
- no req_readyH is generated on that edge.
REQ-014 err_timeoutH clears one cycle after err_clrH=1; a simultaneous set wins over clear.
REQ-015 busyH=1 in LAUNCH, WAIT_BUSY and WAIT_DONE; busyH=0 in IDLE.
REQ-016 A requester that deasserts req_validH before it is accepted is never granted; there is no ordering or storage beyond the single hold register.
REQ-017 Invalid or unreachable FSM encodings return to IDLE on the next clock.

Reset
REQ-018 When sys_rst_l=0, immediately and independent of sys_clk:
- FSM=IDLE;
- req_readyH=0, xmitH=0, xmit_dataH=8'h00, grant_idH=0;
- busyH=0, err_timeoutH=0;
- timeout counter=0, priority pointer=0.
REQ-019 Reset in mid-frame abandons the frame; after reset release, the first grant follows REQ-007 from index 0.

Verification
REQ-020 Single request:
- stimulus: req_validH=4'b0010, req_dataH[15:8]=8'hA5, xmit_doneH=1;
- response: req_readyH=4'b0010 for 1 cycle, grant_idH=1, xmitH pulses the next cycle with xmit_dataH=8'hA5, busyH=1.
REQ-021 Round-robin:
- stimulus: all four requests held valid; the model transmitter finishes each frame;
- response: grant order 0,1,2,3,0.
REQ-022 Transmitter busy:
- stimulus: xmit_doneH=0 in IDLE with req_validH=4'b0001;
- response: no req_readyH until xmit_doneH=1.
REQ-023 Busy timeout:
- stimulus: TIMEOUT=8; after xmitH, xmit_doneH stays 1;
- response: after 8 cycles in WAIT_BUSY, err_timeoutH=1, FSM in IDLE; err_clrH=1 clears the flag the next cycle.
REQ-024 Reset mid-frame:
- stimulus: assert sys_rst_l=0 in WAIT_DONE;
- response: xmitH=0, busyH=0, xmit_dataH=8'h00 without a clock edge; the next grant goes to the lowest valid index.

Source files
------------

// File: rtl/u_xmit_arb.sv
// u_xmit_arb: round-robin arbiter that feeds single bytes from NUM_REQ
// requesters into one UART transmitter. A byte is accepted into a hold
// register, launched with a one-cycle xmitH strobe, and the FSM then follows
// the transmitter through busy and done. A sticky flag records when the
// transmitter fails to respond within TIMEOUT cycles.
module u_xmit_arb #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2,
   parameter int TIMEOUT = 255
) (
   input  logic                   sys_clk,
   input  logic                   sys_rst_l,
   input  logic [NUM_REQ-1:0]     req_validH,
   input  logic [8*NUM_REQ-1:0]   req_dataH,
   output logic [NUM_REQ-1:0]     req_readyH,
   output logic                   xmitH,
   output logic [7:0]             xmit_dataH,
   input  logic                   xmit_doneH,
   output logic [ID_W-1:0]        grant_idH,
   output logic                   busyH,
   output logic                   err_timeoutH,
   input  logic                   err_clrH
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LAUNCH    = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } state_t;

   state_t          state;
   logic [ID_W-1:0] ptr;        // index holding the highest priority
   logic [7:0]      cnt;        // cycles spent in the current wait state
   logic [ID_W-1:0] sel;        // round-robin winner
   logic [ID_W-1:0] rr_idx;
   logic            sel_found;
   logic            accept;
   logic [7:0]      cnt_inc;
   logic            cnt_hit;
   logic            timeout_set;

   // Round-robin scan starting at ptr; first valid requester wins.
   // NOTE: every variable written here gets a default first, otherwise
   // paths that skip the assignment infer a latch.
   always_comb begin
      sel       = '0;
      sel_found = 1'b0;
      rr_idx    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         rr_idx = ID_W'((int'(ptr) + i) % NUM_REQ);
         if (!sel_found && req_validH[rr_idx]) begin
            sel_found = 1'b1;
            sel       = rr_idx;
         end
      end
   end

   assign accept = (state == IDLE) && xmit_doneH && sel_found;

   // Ready is the handshake for the current cycle; the byte is taken on the
   // closing edge. Gated by reset so it is low the instant reset asserts.
   assign req_readyH = (accept && sys_rst_l) ? (NUM_REQ'(1) << sel) : '0;

   // Wait-state counter saturates at 255; a hit means this cycle completes
   // TIMEOUT cycles in the wait state without the transmitter responding.
   assign cnt_inc     = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
   assign cnt_hit     = (cnt_inc == 8'(TIMEOUT));
   assign timeout_set = cnt_hit &&
                        (((state == WAIT_BUSY) &&  xmit_doneH) ||
                         ((state == WAIT_DONE) && !xmit_doneH));

   // Strobe and status are pure decodes of the state register.
   assign xmitH = (state == LAUNCH);
   assign busyH = (state != IDLE);

   // Main FSM with hold register, grant index, pointer, counter and error flag.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge sys_clk or negedge sys_rst_l) begin
      if (!sys_rst_l) begin
         state        <= IDLE;
         ptr          <= '0;
         cnt          <= '0;
         grant_idH    <= '0;
         xmit_dataH   <= 8'h00;
         err_timeoutH <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               cnt <= '0;
               if (accept) begin
                  xmit_dataH <= req_dataH[{sel, 3'b000} +: 8];
                  grant_idH  <= sel;
                  ptr        <= (sel == ID_W'(NUM_REQ - 1)) ? '0 : sel + ID_W'(1);
                  state      <= LAUNCH;
               end
            end
            LAUNCH: begin
               cnt   <= '0;
               state <= WAIT_BUSY;
            end
            WAIT_BUSY: begin
               if (!xmit_doneH) begin
                  cnt   <= '0;
                  state <= WAIT_DONE;
               end else if (cnt_hit) begin
                  cnt   <= '0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            WAIT_DONE: begin
               if (xmit_doneH || cnt_hit) begin
                  cnt   <= '0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            default: begin
               cnt   <= '0;
               state <= IDLE;
            end
         endcase

         // Timeout set takes precedence over a simultaneous clear.
         if (timeout_set)
            err_timeoutH <= 1'b1;
         else if (err_clrH)
            err_timeoutH <= 1'b0;
      end
   end

endmodule

// File: tb/tb_u_xmit_arb.sv
// Scoreboard bench for u_xmit_arb: stimulus pushes expected grants into a
// queue, a negedge monitor pops them when the DUT raises ready / xmitH.
module tb_u_xmit_arb;

   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;
   localparam int TIMEOUT = 8;

   logic              sys_clk = 1'b0;
   logic              sys_rst_l;
   logic [3:0]        req_validH;
   logic [31:0]       req_dataH;
   logic [3:0]        req_readyH;
   logic              xmitH;
   logic [7:0]        xmit_dataH;
   logic              xmit_doneH;
   logic [1:0]        grant_idH;
   logic              busyH;
   logic              err_timeoutH;
   logic              err_clrH;

   logic              tx_model_en;
   logic              model_done;
   logic              manual_done;

   typedef struct packed {
      logic [1:0] idx;
      logic [7:0] data;
   } exp_t;

   exp_t exp_q[$];
   exp_t launch_q[$];
   int   n_cmp        = 0;
   int   n_err        = 0;
   int   accept_count = 0;

   assign xmit_doneH = tx_model_en ? model_done : manual_done;

   u_xmit_arb #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
      .sys_clk      (sys_clk),
      .sys_rst_l    (sys_rst_l),
      .req_validH   (req_validH),
      .req_dataH    (req_dataH),
      .req_readyH   (req_readyH),
      .xmitH        (xmitH),
      .xmit_dataH   (xmit_dataH),
      .xmit_doneH   (xmit_doneH),
      .grant_idH    (grant_idH),
      .busyH        (busyH),
      .err_timeoutH (err_timeoutH),
      .err_clrH     (err_clrH)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
      end
   endtask

   task automatic push_exp(input logic [1:0] idx, input logic [7:0] data);
      exp_t e;
      e.idx  = idx;
      e.data = data;
      exp_q.push_back(e);
   endtask

   // Monitor: pops the expected grant on each ready pulse, then checks the
   // launched byte on the following xmitH strobe.
   always @(negedge sys_clk) begin
      exp_t e;
      if (sys_rst_l) begin
         if (req_readyH != 4'b0000) begin
            if (exp_q.size() == 0) begin
               check("unexpected_ready", 32'(req_readyH), 32'h0);
            end else begin
               e = exp_q.pop_front();
               check("ready_onehot", 32'(req_readyH), 32'(4'b0001 << e.idx));
               check("xmit_low_at_accept", 32'(xmitH), 32'h0);
               launch_q.push_back(e);
               accept_count++;
            end
         end
         if (xmitH) begin
            if (launch_q.size() == 0) begin
               check("unexpected_xmit", 32'(xmitH), 32'h0);
            end else begin
               e = launch_q.pop_front();
               check("xmit_data", 32'(xmit_dataH), 32'(e.data));
               check("grant_id", 32'(grant_idH), 32'(e.idx));
               check("busy_in_launch", 32'(busyH), 32'h1);
            end
         end
      end
   end

   // Model transmitter: busy for a few cycles after each launch.
   initial begin
      model_done = 1'b1;
      forever begin
         @(negedge sys_clk);
         if (tx_model_en && xmitH) begin
            model_done = 1'b0;
            repeat (3) @(negedge sys_clk);
            model_done = 1'b1;
         end
      end
   end

   task automatic do_reset();
      sys_rst_l = 1'b0;
      repeat (3) @(posedge sys_clk);
      #1 sys_rst_l = 1'b1;
   endtask

   task automatic wait_accept(input int target, input string name);
      int n = 0;
      while (accept_count < target && n < 60) begin
         @(posedge sys_clk);
         n++;
      end
      check({name, "_accept_seen"}, 32'(accept_count >= target), 32'h1);
      #1;
   endtask

   task automatic wait_launch(input string name);
      int n = 0;
      @(negedge sys_clk);
      while (!xmitH && n < 20) begin
         @(negedge sys_clk);
         n++;
      end
      check({name, "_launch_seen"}, 32'(xmitH), 32'h1);
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      @(negedge sys_clk);
      while (busyH && n < 60) begin
         @(negedge sys_clk);
         n++;
      end
      check({name, "_idle_seen"}, 32'(busyH), 32'h0);
      @(posedge sys_clk);
      #1;
   endtask

   task automatic manual_finish(input string name);
      wait_launch(name);
      manual_done = 1'b0;
      repeat (2) @(negedge sys_clk);
      manual_done = 1'b1;
      wait_idle(name);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      sys_rst_l   = 1'b0;
      req_validH  = 4'b1111;
      req_dataH   = 32'h4433_2211;
      manual_done = 1'b1;
      tx_model_en = 1'b0;
      err_clrH    = 1'b0;

      // Reset state, with requests and an idle transmitter present.
      #12;
      check("rst_ready", 32'(req_readyH), 32'h0);
      check("rst_xmit", 32'(xmitH), 32'h0);
      check("rst_data", 32'(xmit_dataH), 32'h0);
      check("rst_grant", 32'(grant_idH), 32'h0);
      check("rst_busy", 32'(busyH), 32'h0);
      check("rst_err", 32'(err_timeoutH), 32'h0);
      req_validH = 4'b0000;
      @(posedge sys_clk);
      #1 sys_rst_l = 1'b1;
      @(posedge sys_clk);
      #1;

      // Single request from requester 1.
      req_dataH = 32'h0000_A500;
      push_exp(2'd1, 8'hA5);
      req_validH = 4'b0010;
      wait_accept(accept_count + 1, "single");
      req_validH = 4'b0000;
      manual_finish("single");

      // Round-robin with all four requests held valid.
      do_reset();
      req_dataH = 32'h4433_2211;
      push_exp(2'd0, 8'h11);
      push_exp(2'd1, 8'h22);
      push_exp(2'd2, 8'h33);
      push_exp(2'd3, 8'h44);
      push_exp(2'd0, 8'h11);
      tx_model_en = 1'b1;
      base = accept_count;
      req_validH = 4'b1111;
      wait_accept(base + 5, "rr");
      req_validH = 4'b0000;
      wait_idle("rr");
      tx_model_en = 1'b0;

      // Transmitter busy in IDLE; requester 1 withdraws before acceptance.
      manual_done = 1'b0;
      req_dataH   = 32'h0000_553C;
      req_validH  = 4'b0011;
      for (int k = 0; k < 4; k++) begin
         @(negedge sys_clk);
         check("ready_while_tx_busy", 32'(req_readyH), 32'h0);
         check("idle_while_tx_busy", 32'(busyH), 32'h0);
      end
      @(posedge sys_clk);
      #1 req_validH = 4'b0001;
      @(posedge sys_clk);
      #1;
      push_exp(2'd0, 8'h3C);
      manual_done = 1'b1;
      wait_accept(accept_count + 1, "txbusy");
      req_validH = 4'b0000;
      manual_finish("txbusy");

      // Timeout in WAIT_BUSY: transmitter never drops done.
      req_dataH = 32'h0077_0000;
      push_exp(2'd2, 8'h77);
      req_validH = 4'b0100;
      wait_accept(accept_count + 1, "tmo_busy");
      req_validH = 4'b0000;
      wait_launch("tmo_busy");
      for (int k = 1; k <= TIMEOUT; k++) begin
         @(negedge sys_clk);
         check("tmo_busy_wait_busy", 32'(busyH), 32'h1);
         check("tmo_busy_wait_err", 32'(err_timeoutH), 32'h0);
      end
      @(negedge sys_clk);
      check("tmo_busy_idle", 32'(busyH), 32'h0);
      check("tmo_busy_err_set", 32'(err_timeoutH), 32'h1);
      @(negedge sys_clk);
      check("tmo_busy_err_sticky", 32'(err_timeoutH), 32'h1);
      @(posedge sys_clk);
      #1 err_clrH = 1'b1;
      @(negedge sys_clk);
      check("err_before_clr_edge", 32'(err_timeoutH), 32'h1);
      @(posedge sys_clk);
      #1 err_clrH = 1'b0;
      @(negedge sys_clk);
      check("err_cleared", 32'(err_timeoutH), 32'h0);

      // Timeout in WAIT_DONE with clear held: set wins over clear.
      req_dataH = 32'h5A00_0000;
      push_exp(2'd3, 8'h5A);
      req_validH = 4'b1000;
      wait_accept(accept_count + 1, "tmo_done");
      req_validH = 4'b0000;
      err_clrH = 1'b1;
      wait_launch("tmo_done");
      manual_done = 1'b0;
      for (int k = 1; k <= TIMEOUT + 1; k++) begin
         @(negedge sys_clk);
         check("tmo_done_wait_busy", 32'(busyH), 32'h1);
         check("tmo_done_wait_err", 32'(err_timeoutH), 32'h0);
      end
      @(negedge sys_clk);
      check("tmo_done_idle", 32'(busyH), 32'h0);
      check("set_wins_over_clr", 32'(err_timeoutH), 32'h1);
      @(negedge sys_clk);
      check("clr_after_set", 32'(err_timeoutH), 32'h0);
      @(posedge sys_clk);
      #1;
      err_clrH    = 1'b0;
      manual_done = 1'b1;

      // Reset in the middle of a frame, then pointer restarts from index 0.
      req_dataH = 32'h0000_9900;
      push_exp(2'd1, 8'h99);
      req_validH = 4'b0010;
      wait_accept(accept_count + 1, "midrst");
      req_validH = 4'b0000;
      wait_launch("midrst");
      manual_done = 1'b0;
      repeat (3) @(negedge sys_clk);
      check("midrst_in_frame", 32'(busyH), 32'h1);
      #2 sys_rst_l = 1'b0;
      #1;
      check("midrst_xmit", 32'(xmitH), 32'h0);
      check("midrst_busy", 32'(busyH), 32'h0);
      check("midrst_data", 32'(xmit_dataH), 32'h0);
      check("midrst_grant", 32'(grant_idH), 32'h0);
      req_dataH   = 32'h3300_1100;
      req_validH  = 4'b1010;
      manual_done = 1'b1;
      push_exp(2'd1, 8'h11);
      @(posedge sys_clk);
      #1 sys_rst_l = 1'b1;
      wait_accept(accept_count + 1, "post_rst");
      req_validH = 4'b0000;
      manual_finish("post_rst");

      check("exp_q_drained", 32'(exp_q.size()), 32'h0);
      check("launch_q_drained", 32'(launch_q.size()), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
